// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a 2-cycle-latency instruction BRAM with tagged in-flight
// requests, credit-limited skid FIFO, backpressure and redirect. Optional counters: FETCH_PERF_EN.
//
// state   | meaning
// S_RUN   | issuing one request per cycle while credit is available
// S_STALL | no credit; waiting for the FIFO to drain, pc held
// S_REDIR | one bubble cycle after a redirect before fetch restarts
module fetch_ctrl #(
  parameter int PC_WIDTH                = 32,
  parameter int INST_WIDTH              = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STEP                 = 4,
  parameter int BUF_DEPTH               = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PC_WIDTH-1:0]   imem_addr_o,
  output logic                  imem_en_o,
  input  logic [INST_WIDTH-1:0] imem_data_i,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PC_WIDTH-1:0]   out_pc_o,
`ifdef FETCH_PERF_EN
  output logic [31:0]           perf_fetch_cnt_o,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [15:0]           perf_flush_cnt_o,
`endif
  output logic [INST_WIDTH-1:0] out_inst_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_REDIR} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                s0_v, s1_v;
  logic [PC_WIDTH-1:0] s0_pc, s1_pc;

  logic [PC_WIDTH-1:0]   buf_pc   [BUF_DEPTH];
  logic [INST_WIDTH-1:0] buf_inst [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W:0]        occupancy;
  logic                  credit, issue, push, pop, fifo_nonempty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts words in flight plus words already buffered, so a push always finds room.
  always_comb begin
    occupancy = (CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(s0_v) + (CNT_W+1)'(s1_v);
    credit    = occupancy < (CNT_W+1)'(BUF_DEPTH);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    if (redirect_i) begin
      state_d = S_REDIR;
      pc_d    = redirect_pc_i;
    end else begin
      case (state_q)
        S_RUN: begin
          if (credit) begin
            issue = ~rst;
            pc_d  = pc_q + PC_WIDTH'(PC_STEP);
          end else begin
            state_d = S_STALL;
          end
        end
        S_STALL: if (credit) state_d = S_RUN;
        S_REDIR: state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign imem_en_o   = issue;

  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      s0_v <= 1'b0;
      s1_v <= 1'b0;
    end else begin
      s0_v <= imem_en_o;
      s1_v <= s0_v;
    end
  end

  always_ff @(posedge clk) begin
    s0_pc <= pc_q;
    s1_pc <= s0_pc;
  end

  assign fifo_nonempty = (fifo_cnt != '0);
  assign push          = s1_v & ~redirect_i;
  assign pop           = out_valid_o & out_ready_i;

  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= s1_pc;
      buf_inst[wr_ptr] <= imem_data_i;
    end
  end

  // The FIFO head is the output register; outputs read zero when nothing is buffered.
  assign out_valid_o = fifo_nonempty & ~redirect_i & ~rst;
  assign out_pc_o    = fifo_nonempty ? buf_pc[rd_ptr]   : '0;
  assign out_inst_o  = fifo_nonempty ? buf_inst[rd_ptr] : '0;

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_cnt == CNT_W'(BUF_DEPTH)));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (issue)              perf_fetch_cnt_o <= perf_fetch_cnt_o + 1'b1;
      if (state_q == S_STALL) perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
      if (redirect_i)         perf_flush_cnt_o <= perf_flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule
